// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: state codes,
// opcodes and the datapath mux/ALU encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMREAD  = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWRITE = 4'd6,
    ST_EXECUTER = 4'd7,
    ST_EXECUTEI = 4'd8,
    ST_ALUWB    = 4'd9,
    ST_BEQ      = 4'd10,
    ST_JAL      = 4'd11
  } state_e;

  // Which flavour of ALU operation the current state asks for
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_RTYPE = 2'd2,
    ALU_CLS_ITYPE = 2'd3
  } alu_class_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the state's ALU class plus funct3/funct7b5 onto an ALU operation,
// flagging funct3 values the core does not implement.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [2:0]  alu_control,
  output logic        alu_illegal
);

  // ALU operation and legality for the requested class
  always_comb begin
    alu_control = ALU_ADD;
    alu_illegal = 1'b0;
    case (alu_class)
      ALU_CLS_ADD: alu_control = ALU_ADD;
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_RTYPE, ALU_CLS_ITYPE: begin
        case (funct3)
          3'b000: begin
            // addi has no subtract form, so funct7b5 only matters for R-type
            if ((alu_class == ALU_CLS_RTYPE) && funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: begin
            alu_control = ALU_ADD;
            alu_illegal = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RISC-V core: sequences each instruction
// and drives the datapath register enables and mux selects.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               reg_write,
  output logic               illegal_instr,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     state_r;
  state_e     state_next_s;
  alu_class_e alu_class_s;
  logic       dec_illegal_s;
  logic       exec_state_s;
  logic       wb_block_r;

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class_s),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control),
    .alu_illegal (dec_illegal_s)
  );

  assign exec_state_s = (state_r == ST_EXECUTER) || (state_r == ST_EXECUTEI);
  assign state_dbg    = STATE_W'(state_r);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Remember an unsupported funct3 so the following ALUWB suppresses its write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_block_r <= 1'b0;
    end else begin
      wb_block_r <= exec_state_s && dec_illegal_s;
    end
  end

  // ALU class requested by the current state
  always_comb begin
    alu_class_s = ALU_CLS_ADD;
    case (state_r)
      ST_BEQ:      alu_class_s = ALU_CLS_SUB;
      ST_EXECUTER: alu_class_s = ALU_CLS_RTYPE;
      ST_EXECUTEI: alu_class_s = ALU_CLS_ITYPE;
      default:     alu_class_s = ALU_CLS_ADD;
    endcase
  end

  // Next-state and control strobes
  always_comb begin
    state_next_s  = state_r;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;
    if (state_r == ST_IDLE) begin
      imm_src = IMM_I;
    end else begin
      imm_src = imm_sel(op);
    end

    case (state_r)
      ST_IDLE: state_next_s = ST_FETCH;
      ST_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next_s = ST_MEMADR;
          OP_RTYPE:     state_next_s = ST_EXECUTER;
          OP_ITYPE:     state_next_s = ST_EXECUTEI;
          OP_BEQ:       state_next_s = ST_BEQ;
          OP_JAL:       state_next_s = ST_JAL;
          default: begin
            illegal_instr = 1'b1;
            instr_done    = 1'b1;
            state_next_s  = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW) begin
          state_next_s = ST_MEMREAD;
        end else begin
          state_next_s = ST_MEMWRITE;
        end
      end
      ST_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) begin
          state_next_s = ST_MEMWB;
        end else begin
          state_next_s = ST_MEMREAD;
        end
      end
      ST_MEMWB: begin
        result_src   = RES_DATA;
        reg_write    = 1'b1;
        instr_done   = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        if (mem_ready) begin
          instr_done   = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_MEMWRITE;
        end
      end
      ST_EXECUTER: begin
        alu_src_a     = SRCA_A;
        alu_src_b     = SRCB_B;
        illegal_instr = dec_illegal_s;
        state_next_s  = ST_ALUWB;
      end
      ST_EXECUTEI: begin
        alu_src_a     = SRCA_A;
        alu_src_b     = SRCB_IMM;
        illegal_instr = dec_illegal_s;
        state_next_s  = ST_ALUWB;
      end
      ST_ALUWB: begin
        result_src   = RES_ALUOUT;
        reg_write    = !wb_block_r;
        instr_done   = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_BEQ: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_B;
        result_src = RES_ALUOUT;
        // Only funct3=000 (beq) is a supported branch
        if (funct3 == 3'b000) begin
          pc_write = zero;
        end else begin
          pc_write      = 1'b0;
          illegal_instr = 1'b1;
        end
        instr_done   = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALUOUT;
        pc_write     = 1'b1;
        state_next_s = ST_ALUWB;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction expectations are
// derived from cycle offsets within the instruction and its memory wait counts.
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  localparam int C_LW  = 0;
  localparam int C_SW  = 1;
  localparam int C_R   = 2;
  localparam int C_I   = 3;
  localparam int C_BEQ = 4;
  localparam int C_JAL = 5;
  localparam int C_BAD = 6;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       reg_write, illegal_instr, instr_done;
  logic [3:0] state_dbg;
  logic [17:0] outs;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .instr_done(instr_done), .state_dbg(state_dbg)
  );

  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, alu_control, reg_write, illegal_instr, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_known_op(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
  endfunction

  // One instruction: fw fetch wait cycles, dw data wait cycles (lw/sw only)
  task automatic run_instr(input int cls, input logic [6:0] bad_op, input logic [2:0] f3,
                           input logic f7, input logic z, input int fw, input int dw);
    int len, ms, me;
    logic is_mem, legal_f3, writes, pcw, ill;
    logic [6:0] opc;
    logic [1:0] imm_exp;
    logic [2:0] alu_exp;
    logic [6:0] exp_s, got_s;
    is_mem   = (cls == C_LW) || (cls == C_SW);
    legal_f3 = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    writes   = (cls == C_LW) || (cls == C_JAL) || (((cls == C_R) || (cls == C_I)) && legal_f3);
    imm_exp  = 2'b00;
    case (cls)
      C_LW:  begin opc = 7'b0000011; len = 5 + fw + dw; end
      C_SW:  begin opc = 7'b0100011; len = 4 + fw + dw; imm_exp = 2'b01; end
      C_R:   begin opc = 7'b0110011; len = 4 + fw; end
      C_I:   begin opc = 7'b0010011; len = 4 + fw; end
      C_BEQ: begin opc = 7'b1100011; len = 3 + fw; imm_exp = 2'b10; end
      C_JAL: begin opc = 7'b1101111; len = 4 + fw; imm_exp = 2'b11; end
      default: begin opc = bad_op; len = 2 + fw; end
    endcase
    case (f3)
      3'd0:    alu_exp = ((cls == C_R) && f7) ? 3'b001 : 3'b000;
      3'd2:    alu_exp = 3'b101;
      3'd6:    alu_exp = 3'b011;
      3'd7:    alu_exp = 3'b010;
      default: alu_exp = 3'b000;
    endcase
    if (cls == C_BEQ) alu_exp = 3'b001;
    ms = fw + 3;
    me = fw + 3 + dw;
    op = opc; funct3 = f3; funct7b5 = f7; zero = z;
    for (int c = 0; c < len; c++) begin
      if (c < fw) mem_ready = 1'b0;
      else if (c == fw) mem_ready = 1'b1;
      else if (is_mem && c >= ms && c < me) mem_ready = 1'b0;
      else if (is_mem && c == me) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      @(negedge clk);
      pcw = (c == fw) || ((cls == C_JAL) && (c == fw + 2)) ||
            ((cls == C_BEQ) && (c == fw + 2) && z && (f3 == 3'd0));
      ill = ((cls == C_BAD) && (c == fw + 1)) ||
            (((cls == C_R) || (cls == C_I)) && !legal_f3 && (c == fw + 2)) ||
            ((cls == C_BEQ) && (f3 != 3'd0) && (c == fw + 2));
      exp_s = {pcw, (c == fw), ((cls == C_SW) && c >= ms && c <= me),
               (writes && (c == len - 1)), ill, (c == len - 1), (is_mem && c >= ms && c <= me)};
      got_s = {pc_write, ir_write, mem_write, reg_write, illegal_instr, instr_done, adr_src};
      check_eq($sformatf("strobes cls%0d c%0d", cls, c), 32'(got_s), 32'(exp_s));
      if (c == 0) check_eq("state at fetch", 32'(state_dbg), 32'(ST_FETCH));
      if (c <= fw) check_eq("fetch selects", 32'({result_src, alu_src_a, alu_src_b}), 32'(6'b10_00_10));
      if (c == fw + 1)
        check_eq($sformatf("decode cls%0d", cls), 32'({imm_src, alu_src_a, alu_src_b, alu_control}),
                 32'({imm_exp, 2'b01, 2'b01, 3'b000}));
      if ((c == fw + 2) && ((cls == C_BEQ) || (((cls == C_R) || (cls == C_I)) && legal_f3)))
        check_eq($sformatf("alu_control cls%0d f3=%0d", cls, f3), 32'(alu_control), 32'(alu_exp));
      if ((cls == C_LW) && (c == len - 1)) check_eq("lw result_src", 32'(result_src), 32'(2'b01));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cls, fw, dw;
    logic [6:0] bop;
    logic [2:0] f3;
    reset = 1'b1; mem_ready = 1'b1;
    op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom); zero = 1'($urandom);
    #1 reset = 1'b0;
    #2 check_eq("reset outs", 32'(outs), 32'd0);
    check_eq("reset state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    zero = 1'($urandom); mem_ready = 1'($urandom);
    #1 check_eq("reset outs rand", 32'(outs), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check_eq("idle state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("idle outs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    check_eq("first fetch", 32'(state_dbg), 32'(ST_FETCH));

    run_instr(C_LW,  7'h00, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(C_SW,  7'h00, 3'd2, 1'b0, 1'b0, 0, 3);
    run_instr(C_R,   7'h00, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(C_I,   7'h00, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(C_BEQ, 7'h00, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(C_BEQ, 7'h00, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(C_BAD, 7'h7f, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(C_R,   7'h00, 3'd5, 1'b0, 1'b0, 1, 0);
    run_instr(C_JAL, 7'h00, 3'd0, 1'b0, 1'b0, 2, 0);

    for (int i = 0; i < 150; i++) begin
      cls = int'($urandom_range(0, 6));
      fw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      dw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      bop = 7'($urandom);
      if (is_known_op(bop)) bop = 7'h7f;
      f3 = 3'($urandom);
      if ((cls == C_BEQ) && ($urandom_range(0, 3) != 0)) f3 = 3'd0;
      run_instr(cls, bop, f3, 1'($urandom), 1'($urandom), fw, dw);
    end

    // Reset asserted while an lw is stalled in its data read
    op = 7'b0000011; funct3 = 3'd2; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("memread state", 32'(state_dbg), 32'(ST_MEMREAD));
    check_eq("memread adr_src", 32'(adr_src), 32'd1);
    #2 reset = 1'b0;
    #1 check_eq("midreset outs", 32'(outs), 32'd0);
    check_eq("midreset state", 32'(state_dbg), 32'(ST_IDLE));
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("held reset outs", 32'(outs), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("post reset fetch", 32'(state_dbg), 32'(ST_FETCH));
    run_instr(C_LW, 7'h00, 3'd2, 1'b0, 1'b0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit of the multicycle RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the write enables and the mux selects of the datapath state registers (PC, OldPC, IR, MDR, A/B, ALUOut), which update on those strobes. It sits directly upstream of the datapath register bank and handshakes with instruction/data memory through a single ready input.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register and the `state_dbg` output.

Ports:
- `clk`, in, 1, rising-edge clock.
- `reset`, in, 1, asynchronous, active-low reset.
- `op`, in, 7, IR[6:0].
- `funct3`, in, 3, IR[14:12].
- `funct7b5`, in, 1, IR[30].
- `zero`, in, 1, ALU zero flag.
- `mem_ready`, in, 1, memory has completed the current access.
- `pc_write`, out, 1, PC register enable.
- `adr_src`, out, 1, address select: 0 = PC, 1 = Result.
- `mem_write`, out, 1, data memory write strobe.
- `ir_write`, out, 1, IR and OldPC enable.
- `result_src`, out, 2, result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`, out, 2, ALU A select: 00 = PC, 01 = OldPC, 10 = A.
- `alu_src_b`, out, 2, ALU B select: 00 = B, 01 = ImmExt, 10 = constant 4.
- `imm_src`, out, 2, immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control`, out, 3, ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `reg_write`, out, 1, register file write enable.
- `illegal_instr`, out, 1, one-cycle pulse on an unsupported encoding.
- `instr_done`, out, 1, one-cycle pulse in the final state of each instruction.
- `state_dbg`, out, `STATE_W`, current state.

## Operation
- States:
  - IDLE
  - FETCH
  - DECODE
  - MEMADR
  - MEMREAD
  - MEMWB
  - MEMWRITE
  - EXECUTER
  - EXECUTEI
  - ALUWB
  - BEQ
  - JAL
- Reset forces IDLE. While reset is asserted and in IDLE, every output is 0 and `state_dbg` shows the IDLE code. IDLE always goes to FETCH on the next clock edge.
- FETCH: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10.
  - Holds while `mem_ready`=0; `ir_write` and the PC update are both 0 while holding.
  - On `mem_ready`=1, `ir_write`=1 and `pc_write`=1, then go to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_control`=add (computes the branch/jump target). Next state by `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Any other `op` → pulse `illegal_instr`, assert `instr_done`, go to FETCH.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: `adr_src`=1, `result_src`=00. Holds until `mem_ready`=1, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1, then go to FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=00.
  - `mem_write`=1 on every cycle spent in this state.
  - Exits to FETCH on `mem_ready`=1, with `instr_done` asserted in that cycle.
- EXECUTER: `alu_src_a`=10, `alu_src_b`=00, then go to ALUWB.
- EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, then go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1, then go to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_control`=sub, `result_src`=00.
  - `pc_write` = `zero`.
  - `instr_done`=1, then go to FETCH.
  - If `funct3`≠000, pulse `illegal_instr` and hold `pc_write`=0.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_write`=1, then go to ALUWB.
- `alu_control` derivation:
  - add in FETCH, DECODE, MEMADR and JAL.
  - sub in BEQ.
  - In EXECUTER and EXECUTEI, decoded from `funct3`:
    - 000: sub only when `funct7b5`=1 in EXECUTER; otherwise add. The I-type form is always add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Any other value: pulse `illegal_instr` and leave `reg_write` low in the following ALUWB.
- `imm_src` comes from `op`: lw/I-ALU = 00, sw = 01, beq = 10, jal = 11, other = 00.
- Every output not listed for a state is 0 in that state.

## Timing
- State register updates on `posedge clk`.
- Outputs are combinational from the current state, plus `op`/`funct3`/`funct7b5`/`zero`/`mem_ready` where stated. The datapath samples them on the next edge.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-ALU, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset asserted mid-instruction goes immediately to IDLE. No further strobes are issued and no partial `reg_write`/`mem_write` occurs after the asynchronous assertion.
- `illegal_instr` and `instr_done` never last longer than one cycle.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the encodings for `alu_control`, `imm_src`, `result_src`, `alu_src_a` and `alu_src_b`.
- Sub-module `alu_decoder`: combinational mapping of {state class, `funct3`, `funct7b5`} to `alu_control` plus an illegal flag.

## Test plan
- Reset asserted with any inputs → all outputs 0, `state_dbg`=IDLE. First clock after release → FETCH.
- lw (`op`=0000011), `mem_ready`=1 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 and `result_src`=01 only in MEMWB; `instr_done` pulses once.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_write`=1 for 4 cycles, then FETCH; 7-cycle total.
- R-type sub (`funct3`=000, `funct7b5`=1) → `alu_control`=001 in EXECUTER, `reg_write`=1 in ALUWB. Same encoding as I-type → add.
- beq with `zero`=1 → `pc_write`=1 in BEQ. With `zero`=0 → `pc_write`=0. Both return to FETCH after 3 cycles.
- `op`=1111111 → `illegal_instr` one-cycle pulse in DECODE, no `reg_write`/`mem_write`, next state FETCH. Reset asserted during MEMREAD → IDLE immediately.
